// File: rtl/linescanner_pkg.sv
// Shared types and default widths for the line-scan sequencer and capture datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package linescanner_pkg;

    localparam int LINE_W_DEF       = 12;
    localparam int PIX_W_DEF        = 12;
    localparam int PERIOD_W_DEF     = 16;
    localparam int TIMEOUT_CLKS_DEF = 4095;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_RISE = 3'd2,
        IN_LINE   = 3'd3,
        GAP       = 3'd4
    } seq_state_t;

endpackage

// File: rtl/linescanner_lval_edge_detect.sv
// Registers lval once and produces single-cycle rise/fall strobes.
// Latency: strobes are combinational in the cycle the new lval level is presented.
// Backpressure: none; lval is a free-running sensor strobe.
//
// Ports:
//   pixel_clock, n_reset : clock and asynchronous active-low reset
//   lval                 : pixel-valid from the capture unit
//   rise / fall          : lval & !lval_q / !lval & lval_q
module linescanner_lval_edge_detect (
    input  logic pixel_clock,
    input  logic n_reset,
    input  logic lval,
    output logic rise,
    output logic fall
);

    logic lval_q;

    always_ff @(posedge pixel_clock or negedge n_reset) begin
        if (!n_reset) begin
            lval_q <= 1'b0;
        end else begin
            lval_q <= lval;
        end
    end

    assign rise = lval & ~lval_q;
    assign fall = ~lval & lval_q;

endmodule

// File: rtl/linescanner_line_sequencer.sv
// Frame sequencer for the line-scan capture unit: arms lines at a fixed period, counts lval pixels, flags errors.
// Latency: line_start/line_done/frame_done are combinational strobes; counters and error flags update one clock later.
// Backpressure: none; start is ignored while busy, abort always wins and returns to IDLE next cycle.
//
// Ports:
//   pixel_clock, n_reset               : sole clock, asynchronous active-low reset
//   start, abort                       : one-cycle frame control requests
//   cfg_num_lines/pixels_per_line/line_period : frame configuration, latched on an accepted start
//   lval                               : pixel-valid from the capture unit
//   capture_enable, busy               : high while a frame is in progress
//   line_start, line_done, frame_done  : one-cycle event strobes
//   line_index, pixel_count            : progress of the current line
//   line_len_err, overrun_err, timeout_err : sticky errors, cleared on the next accepted start
module linescanner_line_sequencer
    import linescanner_pkg::*;
#(
    parameter int LINE_W       = LINE_W_DEF,
    parameter int PIX_W        = PIX_W_DEF,
    parameter int PERIOD_W     = PERIOD_W_DEF,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic                pixel_clock,
    input  logic                n_reset,
    input  logic                start,
    input  logic                abort,
    input  logic [LINE_W-1:0]   cfg_num_lines,
    input  logic [PIX_W-1:0]    cfg_pixels_per_line,
    input  logic [PERIOD_W-1:0] cfg_line_period,
    input  logic                lval,
    output logic                capture_enable,
    output logic                busy,
    output logic                line_start,
    output logic                line_done,
    output logic [LINE_W-1:0]   line_index,
    output logic [PIX_W-1:0]    pixel_count,
    output logic                line_len_err,
    output logic                overrun_err,
    output logic                timeout_err,
    output logic                frame_done
);

    localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT_CLKS);

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic [LINE_W-1:0]     num_lines_q;
    logic [PIX_W-1:0]      ppl_q;
    logic [PERIOD_W-1:0]   period_q;
    // Clocks since the current line was armed (0 in the ARM cycle). It also
    // serves as the arm-to-rise timeout counter, since both start at the arm.
    logic [PERIOD_W-1:0]   period_cnt;
    logic                  rise;
    logic                  fall;
    logic                  last_line;
    logic                  period_done;
    logic                  timeout_hit;

    linescanner_lval_edge_detect u_edge (
        .pixel_clock (pixel_clock),
        .n_reset     (n_reset),
        .lval        (lval),
        .rise        (rise),
        .fall        (fall)
    );

    assign last_line   = (line_index == num_lines_q - LINE_W'(1));
    assign period_done = (period_cnt >= period_q - PERIOD_W'(1));
    assign timeout_hit = (period_cnt == TIMEOUT_CNT);

    assign busy           = (state != IDLE);
    assign capture_enable = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        line_start = 1'b0;
        line_done  = 1'b0;
        frame_done = 1'b0;
        if (abort) begin
            // Aborted frames emit no further events.
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = ARM;
                    end
                end
                ARM: begin
                    state_nxt = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        line_start = 1'b1;
                        state_nxt  = IN_LINE;
                    end else if (timeout_hit) begin
                        frame_done = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
                IN_LINE: begin
                    if (fall) begin
                        line_done = 1'b1;
                        state_nxt = GAP;
                    end
                end
                GAP: begin
                    if (last_line) begin
                        frame_done = 1'b1;
                        state_nxt  = IDLE;
                    end else if (period_done) begin
                        state_nxt = ARM;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clock or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            num_lines_q  <= '0;
            ppl_q        <= '0;
            period_q     <= '0;
            period_cnt   <= '0;
            line_index   <= '0;
            pixel_count  <= '0;
            line_len_err <= 1'b0;
            overrun_err  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!abort) begin
                if (state_nxt == ARM) begin
                    period_cnt <= '0;
                end else if (state != IDLE && period_cnt != '1) begin
                    period_cnt <= period_cnt + PERIOD_W'(1);
                end

                unique case (state)
                    IDLE: begin
                        if (start) begin
                            // Zero lines means one; periods below 2 cannot fit ARM plus a pixel.
                            num_lines_q  <= (cfg_num_lines == '0) ? LINE_W'(1) : cfg_num_lines;
                            ppl_q        <= cfg_pixels_per_line;
                            period_q     <= (cfg_line_period < PERIOD_W'(2)) ? PERIOD_W'(2)
                                                                             : cfg_line_period;
                            line_index   <= '0;
                            pixel_count  <= '0;
                            line_len_err <= 1'b0;
                            overrun_err  <= 1'b0;
                            timeout_err  <= 1'b0;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            pixel_count <= PIX_W'(1);
                        end else if (timeout_hit) begin
                            timeout_err <= 1'b1;
                        end
                    end
                    IN_LINE: begin
                        if (fall) begin
                            if (pixel_count != ppl_q) begin
                                line_len_err <= 1'b1;
                            end
                        end else if (lval) begin
                            if (pixel_count != '1) begin
                                pixel_count <= pixel_count + PIX_W'(1);
                            end
                            if (period_done) begin
                                overrun_err <= 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (!last_line && period_done) begin
                            line_index <= line_index + LINE_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_linescanner_line_sequencer.sv
// Self-checking bench for linescanner_line_sequencer: directed frames from the test plan plus random frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_linescanner_line_sequencer;

    localparam int TMO  = 50;
    localparam int MAXC = 1024;
    // Bit positions inside the expected/observed flag vector.
    localparam int B_BUSY = 7, B_CAP = 6, B_LS = 5, B_LD = 4, B_FD = 3, B_LEN = 2, B_OVR = 1, B_TMO = 0;

    logic        pixel_clock = 1'b0;
    logic        n_reset     = 1'b0;
    logic        start       = 1'b0;
    logic        abort       = 1'b0;
    logic        lval        = 1'b0;
    logic [11:0] cfg_num_lines       = '0;
    logic [11:0] cfg_pixels_per_line = '0;
    logic [15:0] cfg_line_period     = '0;
    logic        capture_enable, busy, line_start, line_done, frame_done;
    logic        line_len_err, overrun_err, timeout_err;
    logic [11:0] line_index;
    logic [11:0] pixel_count;

    linescanner_line_sequencer #(
        .LINE_W(12), .PIX_W(12), .PERIOD_W(16), .TIMEOUT_CLKS(TMO)
    ) dut (
        .pixel_clock         (pixel_clock),
        .n_reset             (n_reset),
        .start               (start),
        .abort               (abort),
        .cfg_num_lines       (cfg_num_lines),
        .cfg_pixels_per_line (cfg_pixels_per_line),
        .cfg_line_period     (cfg_line_period),
        .lval                (lval),
        .capture_enable      (capture_enable),
        .busy                (busy),
        .line_start          (line_start),
        .line_done           (line_done),
        .line_index          (line_index),
        .pixel_count         (pixel_count),
        .line_len_err        (line_len_err),
        .overrun_err         (overrun_err),
        .timeout_err         (timeout_err),
        .frame_done          (frame_done)
    );

    always #5 pixel_clock = ~pixel_clock;

    wire [7:0] obs_fl = {busy, capture_enable, line_start, line_done, frame_done,
                         line_len_err, overrun_err, timeout_err};

    int n_chk = 0;
    int n_err = 0;
    int cur_c = 0;

    // Expected timeline of one frame, indexed by clock cycle (cycle 0 = start cycle).
    logic [7:0] e_fl [MAXC];
    int         e_li [MAXC];
    int         e_pc [MAXC];
    logic       lv   [MAXC];
    int         d_tab [4];
    int         w_tab [4];
    // Values held by the DUT between frames.
    int         p_li  = 0;
    int         p_pc  = 0;
    logic [2:0] p_err = 3'b000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_c, got, exp);
        end
    endtask

    task automatic paint_bit(input int from, input int b, input logic v);
        for (int c = from; c < MAXC; c++) e_fl[c][b] = v;
    endtask

    task automatic paint_li(input int from, input int v);
        for (int c = from; c < MAXC; c++) e_li[c] = v;
    endtask

    task automatic paint_pc(input int from, input int v);
        for (int c = from; c < MAXC; c++) e_pc[c] = v;
    endtask

    // Builds the lval waveform line by line from the line-arm schedule, paints the
    // expected outputs, then drives and checks the frame cycle by cycle.
    task automatic run_frame(input int n_cfg, input int ppl, input int per_cfg,
                             input int ab_in, input int bs_in, input int rc, input bit rnd);
        int n_eff, per_eff, a, t, f, d, w, c0, end_c, len, ab, bs, lim;
        n_eff   = (n_cfg == 0) ? 1 : n_cfg;
        per_eff = (per_cfg < 2) ? 2 : per_cfg;
        for (int c = 0; c < MAXC; c++) begin
            lv[c]   = 1'b0;
            e_fl[c] = {5'b00000, p_err};
            e_li[c] = p_li;
            e_pc[c] = p_pc;
        end
        paint_bit(1, B_BUSY, 1'b1);
        paint_bit(1, B_CAP, 1'b1);
        paint_bit(1, B_LEN, 1'b0);
        paint_bit(1, B_OVR, 1'b0);
        paint_bit(1, B_TMO, 1'b0);
        paint_li(1, 0);
        paint_pc(1, 0);
        a     = 1;
        end_c = 0;
        for (int k = 0; k < n_eff; k++) begin
            if (rnd) begin
                d = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(1, per_eff + 5));
                w = ($urandom_range(0, 1) == 1) ? ppl : int'($urandom_range(1, per_eff + 5));
            end else begin
                d = d_tab[k];
                w = w_tab[k];
            end
            if (k > 0) paint_li(a, k);
            if (d > TMO) begin
                end_c = a + TMO;
                paint_bit(end_c + 1, B_TMO, 1'b1);
                break;
            end
            t = a + d;
            f = t + w;
            for (int i = 0; i < w; i++) begin
                lv[t + i] = 1'b1;
                paint_pc(t + 1 + i, i + 1);
            end
            e_fl[t][B_LS] = 1'b1;
            e_fl[f][B_LD] = 1'b1;
            if (w != ppl) paint_bit(f + 1, B_LEN, 1'b1);
            // First in-line cycle whose period count has reached period-1 with lval high.
            c0 = (t + 1 > a + per_eff - 1) ? t + 1 : a + per_eff - 1;
            if (c0 <= f - 1) paint_bit(c0 + 1, B_OVR, 1'b1);
            if (k == n_eff - 1) begin
                end_c = f + 1;
            end else begin
                a = (f + 2 > a + per_eff) ? f + 2 : a + per_eff;
            end
        end
        e_fl[end_c][B_FD] = 1'b1;
        paint_bit(end_c + 1, B_BUSY, 1'b0);
        paint_bit(end_c + 1, B_CAP, 1'b0);
        len = end_c + 3;

        if (rnd) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, end_c)) : 0;
        end else begin
            ab = ab_in;
        end
        if (ab > end_c) ab = 0;
        if (ab > 0) begin
            for (int c = ab; c < MAXC; c++) begin
                e_fl[c][B_LS] = 1'b0;
                e_fl[c][B_LD] = 1'b0;
                e_fl[c][B_FD] = 1'b0;
            end
            for (int c = ab + 1; c < MAXC; c++) begin
                e_fl[c] = {5'b00000, e_fl[ab][2:0]};
                e_li[c] = e_li[ab];
                e_pc[c] = e_pc[ab];
            end
            len = ab + 3;
        end
        lim = (ab > 0) ? ab : end_c;
        if (rnd) begin
            bs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lim)) : 0;
        end else begin
            bs = bs_in;
        end

        for (int c = 0; c < len; c++) begin
            @(negedge pixel_clock);
            cur_c = c;
            start = (c == 0) || (c == bs);
            abort = (ab > 0) && (c == ab);
            lval  = lv[c];
            if (c == 0) begin
                cfg_num_lines       = 12'(n_cfg);
                cfg_pixels_per_line = 12'(ppl);
                cfg_line_period     = 16'(per_cfg);
            end else if (c == bs) begin
                cfg_num_lines       = 12'($urandom_range(5, 9));
                cfg_pixels_per_line = 12'($urandom_range(11, 40));
                cfg_line_period     = 16'($urandom_range(31, 90));
            end
            #1;
            chk("flags", 32'(obs_fl), 32'(e_fl[c]));
            chk("line_index", 32'(line_index), 32'(e_li[c]));
            chk("pixel_count", 32'(pixel_count), 32'(e_pc[c]));
            if (rc > 0 && c == rc) begin
                #1 n_reset = 1'b0;
                #1;
                chk("rst_flags", 32'(obs_fl), 32'd0);
                chk("rst_line_index", 32'(line_index), 32'd0);
                chk("rst_pixel_count", 32'(pixel_count), 32'd0);
                #1 n_reset = 1'b1;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        lval  = 1'b0;
        if (rc > 0) begin
            p_li  = 0;
            p_pc  = 0;
            p_err = 3'b000;
        end else begin
            p_li  = e_li[len - 1];
            p_pc  = e_pc[len - 1];
            p_err = e_fl[len - 1][2:0];
        end
    endtask

    initial begin
        repeat (3) @(negedge pixel_clock);
        #1;
        chk("reset_flags", 32'(obs_fl), 32'd0);
        chk("reset_line_index", 32'(line_index), 32'd0);
        chk("reset_pixel_count", 32'(pixel_count), 32'd0);
        n_reset = 1'b1;

        // start and abort together in IDLE: abort wins, nothing starts.
        @(negedge pixel_clock);
        start = 1'b1;
        abort = 1'b1;
        cfg_num_lines   = 12'd2;
        cfg_line_period = 16'd10;
        for (int c = 1; c <= 3; c++) begin
            @(negedge pixel_clock);
            start = 1'b0;
            abort = 1'b0;
            cur_c = c;
            #1;
            chk("idle_start_abort", 32'(obs_fl), 32'd0);
        end

        // Nominal: 3 lines of 8 pixels, period 20.
        d_tab = '{2, 2, 2, 2};
        w_tab = '{8, 8, 8, 8};
        run_frame(3, 8, 20, 0, 0, 0, 1'b0);
        // Short second line.
        w_tab = '{8, 6, 8, 8};
        run_frame(3, 8, 20, 0, 0, 0, 1'b0);
        // Overrun: lval high 15 cycles against a 10-clock period.
        d_tab = '{2, 3, 2, 2};
        w_tab = '{15, 15, 8, 8};
        run_frame(2, 15, 10, 0, 0, 0, 1'b0);
        // Timeout: no lval rise on the first line.
        d_tab = '{TMO + 1, 2, 2, 2};
        run_frame(2, 8, 20, 0, 0, 0, 1'b0);
        // Abort at pixel 4, with an ignored start while busy beforehand.
        d_tab = '{2, 2, 2, 2};
        w_tab = '{8, 8, 8, 8};
        run_frame(3, 8, 20, 6, 4, 0, 1'b0);
        // Reset mid-line, then a clean frame.
        run_frame(3, 8, 20, 0, 0, 6, 1'b0);
        run_frame(3, 8, 20, 0, 0, 0, 1'b0);
        // Degenerate config: 0 lines -> 1, period 0 -> 2, 1-pixel line.
        d_tab = '{1, 1, 1, 1};
        w_tab = '{1, 1, 1, 1};
        run_frame(0, 1, 0, 0, 0, 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            run_frame(int'($urandom_range(0, 4)), int'($urandom_range(1, 10)),
                      int'($urandom_range(0, 30)), 0, 0, 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
